// File: rtl/axi_rw_arbiter.sv
// rtl/axi_rw_arbiter.sv - IF/MEM arbiter onto the single rw_* AXI master user port
// Optional: define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests.
module axi_rw_arbiter #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter logic [2:0]  IF_SIZE    = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ready_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic [1:0]            if_resp_o,
  input  logic                  mem_req_i,
  input  logic                  mem_wen_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [2:0]            mem_size_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic [1:0]            mem_resp_o,
  output logic                  rw_id_o,
  output logic                  rw_cen_o,
  output logic                  rw_wen_o,
  output logic [ADDR_WIDTH-1:0] rw_addr_o,
  output logic [2:0]            rw_size_o,
  output logic [DATA_WIDTH-1:0] rw_wdata_o,
  input  logic                  rw_ready_i,
  input  logic [DATA_WIDTH-1:0] rw_rdata_i,
  input  logic [1:0]            rw_resp_i
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RELEASE} state_t;

  state_t state_q, state_d;
  logic   grant;
  logic   grant_mem;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
`endif

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || mem_req_i) begin
          grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          // last_grant holds the id of the previous winner; favour the other side
          if (if_req_i && mem_req_i) grant_mem = ~last_grant_q;
          else                       grant_mem = mem_req_i;
`else
          grant_mem = mem_req_i;
`endif
          state_d = grant_mem ? MEM_BUSY : IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (rw_ready_i) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_cen_o   <= 1'b0;
      rw_id_o    <= 1'b0;
      rw_wen_o   <= 1'b0;
      rw_addr_o  <= '0;
      rw_size_o  <= 3'b000;
      rw_wdata_o <= '0;
    end else begin
      state_q  <= state_d;
      rw_cen_o <= (state_d == IF_BUSY) || (state_d == MEM_BUSY);
      if (grant) begin
        rw_id_o    <= grant_mem;
        rw_wen_o   <= grant_mem & mem_wen_i;
        rw_addr_o  <= grant_mem ? mem_addr_i  : if_addr_i;
        rw_size_o  <= grant_mem ? mem_size_i  : IF_SIZE;
        rw_wdata_o <= grant_mem ? mem_wdata_i : '0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     last_grant_q <= 1'b0;
    else if (grant) last_grant_q <= grant_mem;
  end
`endif

  // Completion is routed only while the matching side owns the port
  always_comb begin
    if_ready_o  = rw_ready_i & (state_q == IF_BUSY);
    mem_ready_o = rw_ready_i & (state_q == MEM_BUSY);
    if_resp_o   = (state_q == IF_BUSY)  ? rw_resp_i : 2'b00;
    mem_resp_o  = (state_q == MEM_BUSY) ? rw_resp_i : 2'b00;
    if_rdata_o  = rw_rdata_i;
    mem_rdata_o = rw_rdata_i;
  end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// tb/tb_axi_rw_arbiter.sv - directed and randomized checks of axi_rw_arbiter
module tb_axi_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_ready_o;
  logic [63:0] if_rdata_o;
  logic [1:0]  if_resp_o;
  logic        mem_req_i;
  logic        mem_wen_i;
  logic [63:0] mem_addr_i;
  logic [2:0]  mem_size_i;
  logic [63:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [63:0] mem_rdata_o;
  logic [1:0]  mem_resp_o;
  logic        rw_id_o;
  logic        rw_cen_o;
  logic        rw_wen_o;
  logic [63:0] rw_addr_o;
  logic [2:0]  rw_size_o;
  logic [63:0] rw_wdata_o;
  logic        rw_ready_i;
  logic [63:0] rw_rdata_i;
  logic [1:0]  rw_resp_i;

  int nchecks = 0;
  int nerr    = 0;
  logic model_last = 1'b0;

  axi_rw_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rdata_o(if_rdata_o), .if_resp_o(if_resp_o),
    .mem_req_i(mem_req_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
    .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i), .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o), .mem_resp_o(mem_resp_o),
    .rw_id_o(rw_id_o), .rw_cen_o(rw_cen_o), .rw_wen_o(rw_wen_o), .rw_addr_o(rw_addr_o),
    .rw_size_o(rw_size_o), .rw_wdata_o(rw_wdata_o),
    .rw_ready_i(rw_ready_i), .rw_rdata_i(rw_rdata_i), .rw_resp_i(rw_resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: who wins arbitration given the two requests and previous winner (1 = MEM)
  function automatic logic pick(input logic ifr, input logic memr, input logic last);
`ifdef ARB_ROUND_ROBIN_EN
    if (ifr && memr) return ~last;
`endif
    return memr;
  endfunction

  task automatic check_grant(input string tag, input logic id, input logic wen,
                             input logic [63:0] addr, input logic [2:0] size,
                             input logic [63:0] wdata);
    check({tag, "_cen"}, rw_cen_o, 1'b1);
    check({tag, "_id"}, rw_id_o, id);
    check({tag, "_wen"}, rw_wen_o, wen);
    check({tag, "_addr"}, rw_addr_o, addr);
    check({tag, "_size"}, rw_size_o, size);
    check({tag, "_wdata"}, rw_wdata_o, wdata);
  endtask

  // Pulse ready in a BUSY cycle, check routing, leave the bench in the RELEASE cycle
  task automatic complete(input string tag, input logic [63:0] rdata, input logic [1:0] resp,
                          input logic is_mem);
    rw_ready_i = 1'b1; rw_rdata_i = rdata; rw_resp_i = resp;
    #1;
    check({tag, "_if_ready"}, if_ready_o, !is_mem);
    check({tag, "_mem_ready"}, mem_ready_o, is_mem);
    check({tag, "_if_resp"}, if_resp_o, is_mem ? 2'b00 : resp);
    check({tag, "_mem_resp"}, mem_resp_o, is_mem ? resp : 2'b00);
    check({tag, "_rdata"}, is_mem ? mem_rdata_o : if_rdata_o, rdata);
    tick();
    rw_ready_i = 1'b0; rw_rdata_i = '0; rw_resp_i = 2'b00;
    check({tag, "_release_cen"}, rw_cen_o, 1'b0);
  endtask

  initial begin
    logic exp_ids [3];
    logic        ifr, memr, win, wen;
    logic [63:0] ia, ma, wd, rd, exp_addr, exp_wd;
    logic [2:0]  sz, exp_sz;
    logic [1:0]  rsp;
    int          lat;

    rst_n = 1'b0; if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_wen_i = 0;
    mem_addr_i = '0; mem_size_i = '0; mem_wdata_i = '0;
    rw_ready_i = 0; rw_rdata_i = '0; rw_resp_i = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_cen", rw_cen_o, 1'b0);
    check("rst_id", rw_id_o, 1'b0);
    check("rst_wen", rw_wen_o, 1'b0);
    check("rst_addr", rw_addr_o, 64'h0);
    check("rst_size", rw_size_o, 3'b000);
    check("rst_wdata", rw_wdata_o, 64'h0);
    tick();

    // 1: single IF fetch
    if_req_i = 1; if_addr_i = 64'h8000_0000;
    tick();
    check_grant("t1", 1'b0, 1'b0, 64'h8000_0000, 3'b010, 64'h0);
    complete("t1", 64'hDEAD_BEEF, 2'b00, 1'b0);
    if_req_i = 0;
    tick();
    check("t1_idle_cen", rw_cen_o, 1'b0);

    // 2 + 5: simultaneous requests, MEM first, IF follows with error response
    if_req_i = 1; if_addr_i = 64'h8000_0040;
    mem_req_i = 1; mem_wen_i = 1; mem_addr_i = 64'h8000_1004; mem_size_i = 3;
    mem_wdata_i = 64'h1122_3344_5566_7788;
    tick();
    check_grant("t2m", 1'b1, 1'b1, 64'h8000_1004, 3'd3, 64'h1122_3344_5566_7788);
    complete("t2m", 64'h0, 2'b00, 1'b1);
    mem_req_i = 0;
    tick();
    check("t2_idle_cen", rw_cen_o, 1'b0);
    tick();
    check_grant("t2i", 1'b0, 1'b0, 64'h8000_0040, 3'b010, 64'h0);
    complete("t5", 64'h1234, 2'b10, 1'b0);
    if_req_i = 0;
    tick();

    // 3: both held through three transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_ids[0] = 1; exp_ids[1] = 0; exp_ids[2] = 1;
`else
    exp_ids[0] = 1; exp_ids[1] = 1; exp_ids[2] = 1;
`endif
    if_req_i = 1; if_addr_i = 64'h1000;
    mem_req_i = 1; mem_wen_i = 0; mem_addr_i = 64'h2000; mem_size_i = 3; mem_wdata_i = 64'h55;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_grant($sformatf("t3_%0d", k), exp_ids[k], 1'b0,
                  exp_ids[k] ? 64'h2000 : 64'h1000, exp_ids[k] ? 3'd3 : 3'b010,
                  exp_ids[k] ? 64'h55 : 64'h0);
      complete($sformatf("t3_%0d", k), 64'hA0 + 64'(k), 2'b00, exp_ids[k]);
      if (k == 2) begin if_req_i = 0; mem_req_i = 0; end
      tick();
    end

    // 4: MEM inputs changing mid-transaction are ignored
    mem_req_i = 1; mem_wen_i = 0; mem_addr_i = 64'h100; mem_size_i = 2;
    tick();
    check("t4_addr0", rw_addr_o, 64'h100);
    mem_addr_i = 64'h200; mem_wen_i = 1;
    tick();
    check("t4_addr1", rw_addr_o, 64'h100);
    check("t4_wen1", rw_wen_o, 1'b0);
    tick();
    check("t4_addr2", rw_addr_o, 64'h100);
    complete("t4", 64'h77, 2'b01, 1'b1);
    check("t4_addr_rel", rw_addr_o, 64'h100);
    mem_req_i = 0;
    tick();

    // 6: reset during MEM_BUSY discards the pending completion
    mem_req_i = 1; mem_wen_i = 1; mem_addr_i = 64'h300; mem_wdata_i = 64'h9;
    tick();
    check("t6_cen_busy", rw_cen_o, 1'b1);
    rst_n = 0;
    tick();
    rst_n = 1; mem_req_i = 0;
    model_last = 1'b0;
    check("t6_cen", rw_cen_o, 1'b0);
    check("t6_addr", rw_addr_o, 64'h0);
    check("t6_id", rw_id_o, 1'b0);
    rw_ready_i = 1; rw_rdata_i = 64'hBAD; rw_resp_i = 2'b11;
    #1;
    check("t6_mem_ready", mem_ready_o, 1'b0);
    check("t6_if_ready", if_ready_o, 1'b0);
    check("t6_mem_resp", mem_resp_o, 2'b00);
    tick();
    rw_ready_i = 0; rw_rdata_i = '0; rw_resp_i = '0;
    check("t6_cen_after", rw_cen_o, 1'b0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      ifr = 1'($urandom); memr = 1'($urandom);
      if (!ifr && !memr) ifr = 1;
      ia = {$urandom, $urandom}; ma = {$urandom, $urandom}; wd = {$urandom, $urandom};
      sz = 3'($urandom_range(0, 3)); wen = 1'($urandom);
      if_req_i = ifr; if_addr_i = ia;
      mem_req_i = memr; mem_addr_i = ma; mem_wdata_i = wd; mem_size_i = sz; mem_wen_i = wen;
      win = pick(ifr, memr, model_last);
      model_last = win;
      exp_addr = win ? ma : ia;
      exp_wd   = win ? wd : 64'h0;
      exp_sz   = win ? sz : 3'b010;
      tick();
      check_grant($sformatf("r%0d", n), win, win & wen, exp_addr, exp_sz, exp_wd);
      lat = $urandom_range(0, 3);
      for (int c = 0; c < lat; c++) begin
        rw_ready_i = 0;
        if_addr_i = {$urandom, $urandom}; mem_addr_i = {$urandom, $urandom};
        mem_wen_i = 1'($urandom); mem_size_i = 3'($urandom);
        tick();
        check($sformatf("r%0d_hold_addr", n), rw_addr_o, exp_addr);
        check($sformatf("r%0d_hold_cen", n), rw_cen_o, 1'b1);
      end
      rd = {$urandom, $urandom}; rsp = 2'($urandom);
      complete($sformatf("r%0d", n), rd, rsp, win);
      if_req_i = 0; mem_req_i = 0;
      tick();
      check($sformatf("r%0d_idle_cen", n), rw_cen_o, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
